// File: rtl/axis2fifo.sv
// axis2fifo: checks AXI4-Stream video frame geometry and packs pixels into
// sof-tagged memory words for the S2MM data FIFO.
module axis2fifo #(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_DATA_WIDTH  = 32,
   parameter int C_IMG_WBITS   = 12,
   parameter int C_IMG_HBITS   = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     soft_resetn,
   input  logic [C_IMG_WBITS-1:0]   img_width,
   input  logic [C_IMG_HBITS-1:0]   img_height,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [C_DATA_WIDTH-1:0]  fifo_dout,
   output logic                     fifo_sof,
   output logic                     frame_done,
   output logic                     frame_err
);
   localparam int PB = C_PIXEL_WIDTH <= 8 ? 1 : C_PIXEL_WIDTH <= 16 ? 2 : 4;
   localparam int LW = PB * 8;
   localparam int P  = C_DATA_WIDTH / LW;
   localparam int LB = P > 1 ? $clog2(P) : 1;
   localparam int HN = P > 1 ? P - 1 : 1;
   localparam logic [LB-1:0] LMAX = LB'(P - 1);

   typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

   state_t                 state;
   logic [C_IMG_WBITS-1:0] w, col, ew, c;
   logic [C_IMG_HBITS-1:0] h, row, eh, r;
   logic [LB-1:0]          lane, l;
   logic [HN*LW-1:0]       hold;
   logic [LW-1:0]          pix;
   logic                   acc, restart, valid, last_col, last_px, bad;

   assign s_axis_tready = ~soft_resetn | state == DROP | ~fifo_full;

   // A sof pixel is evaluated against freshly sampled geometry and cleared counters.
   always_comb begin
      acc       = s_axis_tvalid & s_axis_tready;
      restart   = acc & s_axis_tuser & soft_resetn;
      ew        = restart ? img_width : w;
      eh        = restart ? img_height : h;
      c         = restart ? '0 : col;
      r         = restart ? '0 : row;
      l         = restart ? '0 : lane;
      pix       = LW'(s_axis_tdata);
      valid     = acc & soft_resetn & (restart | state == RUN);
      last_col  = c == ew - 1'b1;
      last_px   = last_col & r == eh - 1'b1;
      bad       = valid & (s_axis_tlast != last_col);
      fifo_wr_en = valid & ~bad & l == LMAX;
      fifo_sof  = fifo_wr_en & r == '0 & c == C_IMG_WBITS'(P - 1);
      fifo_dout = '0;
      fifo_dout[(P-1)*LW +: LW] = pix;
      for (int k = 0; k < P - 1; k++) fifo_dout[k*LW +: LW] = hold[k*LW +: LW];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         lane       <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= fifo_wr_en & last_px;
         frame_err  <= bad | (restart & state == RUN);
         if (restart) begin
            w <= img_width;
            h <= img_height;
         end
         if (!soft_resetn) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            lane  <= '0;
         end else if (bad) begin
            state <= DROP;
            col   <= '0;
            row   <= '0;
            lane  <= '0;
         end else if (valid) begin
            if (l != LMAX) hold[l*LW +: LW] <= pix;
            lane  <= l == LMAX ? '0 : l + 1'b1;
            col   <= last_col ? '0 : c + 1'b1;
            row   <= last_px ? '0 : last_col ? r + 1'b1 : r;
            state <= last_px ? IDLE : RUN;
         end
      end
   end
endmodule

// File: tb/tb_axis2fifo.sv
// tb_axis2fifo: vector table, P = 2 corner case and randomized frame stream
// against a frame-level model for axis2fifo.
module tb_axis2fifo;
   logic        clk = 0, reset = 1, soft_resetn = 1;
   logic [11:0] img_width = 8, img_height = 2;
   logic        tvalid = 0, tready, tuser = 0, tlast = 0, fifo_full = 0;
   logic [7:0]  tdata = 0;
   logic        wr_en, sof, done, err;
   logic [31:0] dout;
   logic        tvalid_b = 0, tready_b, tuser_b = 0, tlast_b = 0;
   logic [9:0]  tdata_b = 0;
   logic [11:0] w_b = 4, h_b = 1;
   logic        wr_b, sof_b, done_b, err_b;
   logic [31:0] dout_b;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   axis2fifo dut (
      .clk(clk), .reset(reset), .soft_resetn(soft_resetn),
      .img_width(img_width), .img_height(img_height),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
      .s_axis_tuser(tuser), .s_axis_tlast(tlast), .fifo_full(fifo_full),
      .fifo_wr_en(wr_en), .fifo_dout(dout), .fifo_sof(sof),
      .frame_done(done), .frame_err(err)
   );

   axis2fifo #(.C_PIXEL_WIDTH(10)) dut_b (
      .clk(clk), .reset(reset), .soft_resetn(1'b1),
      .img_width(w_b), .img_height(h_b),
      .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b), .s_axis_tdata(tdata_b),
      .s_axis_tuser(tuser_b), .s_axis_tlast(tlast_b), .fifo_full(1'b0),
      .fifo_wr_en(wr_b), .fifo_dout(dout_b), .fifo_sof(sof_b),
      .frame_done(done_b), .frame_err(err_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int b);
      return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
   endfunction

   typedef struct {
      bit v; logic [7:0] d; bit u, l, full, sr; logic [11:0] w, h;
      bit rdy, wr; logic [31:0] dout; bit sof, done, err;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input bit v, input logic [7:0] d, input bit u, l, full, sr,
                               input logic [11:0] w, h, input bit rdy, wr,
                               input logic [31:0] dw, input bit s, dn, er);
      vecs.push_back('{v, d, u, l, full, sr, w, h, rdy, wr, dw, s, dn, er});
   endfunction

   // frame-level scoreboard for the randomized section
   logic [31:0] exp_q[$];
   bit          exp_sof_q[$];
   int          exp_done = 0, exp_err = 0, got_done = 0, got_err = 0;
   bit          rnd_on = 0, rnd_full_on = 0;

   always @(negedge clk) if (rnd_on) begin
      if (wr_en) begin
         chk("rnd_wr_while_full", fifo_full, 0);
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rnd_extra_word: got %h expected no write", dout);
         end else begin
            chk("rnd_word", dout, exp_q.pop_front());
            chk("rnd_sof", sof, exp_sof_q.pop_front());
         end
      end
      if (done) got_done++;
      if (err) got_err++;
   end

   always @(posedge clk) if (rnd_full_on) begin
      #1 fifo_full = $urandom_range(0, 3) == 0;
   end

   task automatic px(input logic [7:0] d, input bit u, input bit l);
      tvalid = 1; tdata = d; tuser = u; tlast = l;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tready) begin
            @(posedge clk); #1;
            tvalid = 0; tuser = 0; tlast = 0;
            return;
         end
      end
      tests++; fails++;
      $display("FAIL px_timeout: tready low for 100 cycles, expected accept");
      tvalid = 0;
   endtask

   // mode 0: n correct pixels; mode 1: the n-th pixel carries a wrong tlast
   task automatic send_frame(input int wd, input int ht, input int n, input bit mode);
      logic [7:0] p[$];
      int total = wd * ht, k;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      k = mode ? (n - 1) / 4 : n / 4;
      for (int j = 0; j < k; j++) begin
         exp_q.push_back({p[4*j+3], p[4*j+2], p[4*j+1], p[4*j]});
         exp_sof_q.push_back(j == 0);
      end
      if (!mode && n == total) exp_done++; else exp_err++;
      img_width = 12'(wd); img_height = 12'(ht);
      for (int i = 0; i < n; i++) begin
         bit l = (i % wd) == wd - 1;
         if (mode && i == n - 1) l = !l;
         px(p[i], i == 0, l);
         img_width = 12'($urandom_range(1, 4095)); img_height = 12'($urandom_range(1, 4095));
      end
   endtask

   initial begin
      // reset must override a sof pixel presented during reset
      tvalid = 1; tuser = 1; tdata = 8'h77;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr", wr_en, 0);
      chk("rst_sof", sof, 0);
      reset = 0; tvalid = 0; tuser = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_tready", tready, 1);
      fifo_full = 1; #1;
      chk("rst_tready_full", tready, 0);
      fifo_full = 0;
      @(posedge clk); #1;

      // garbage before sof, then W=8 H=2 frame
      for (int i = 0; i < 5; i++) add(1, 8'(8'hA0 + i), 0, i == 2, 0, 1, 8, 2, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         add(1, 8'(i), i == 0, i % 8 == 7, 0, 1, 8, 2, 1, i % 4 == 3, word(i - 3), i == 3, 0, 0);
      add(0, 0, 0, 0, 0, 1, 8, 2, 1, 0, 0, 0, 1, 0);
      // fifo_full stall mid-word, geometry inputs changed after sof
      for (int i = 0; i < 16; i++) begin
         if (i == 5) repeat (3) add(1, 8'(i), 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
         add(1, 8'(i), i == 0, i % 8 == 7, 0, 1, i == 0 ? 8 : 4, i == 0 ? 2 : 1,
             1, i % 4 == 3, word(i - 3), i == 3, 0, 0);
      end
      add(0, 0, 0, 0, 0, 1, 8, 2, 1, 0, 0, 0, 1, 0);
      // early tlast, drain (tready stays high even when full), next frame
      for (int i = 0; i < 6; i++)
         add(1, 8'(i), i == 0, i == 5, 0, 1, 8, 2, 1, i == 3, word(0), i == 3, 0, 0);
      for (int i = 6; i < 16; i++)
         add(1, 8'(i), 0, i == 7 || i == 15, i < 8, 1, 8, 2, 1, 0, 0, 0, 0, i == 6);
      for (int i = 0; i < 4; i++)
         add(1, 8'(8'h20 + i), i == 0, i == 3, 0, 1, 4, 1, 1, i == 3, word(32'h20), i == 3, 0, 0);
      add(0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 1, 0);
      // soft reset mid row 1, then a new frame
      for (int i = 0; i < 11; i++)
         add(1, 8'(i), i == 0, i == 7, 0, 1, 8, 2, 1, i % 4 == 3, word(i - 3), i == 3, 0, 0);
      for (int k = 0; k < 3; k++) add(1, 8'(8'h40 + k), k == 1, 0, 1, 0, 8, 2, 1, 0, 0, 0, 0, 0);
      add(1, 8'd11, 0, 0, 0, 1, 8, 2, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         add(1, 8'(8'h30 + i), i == 0, i == 3, 0, 1, 4, 1, 1, i == 3, word(32'h30), i == 3, 0, 0);
      add(0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 1, 0);
      // tuser inside a running frame restarts it with an error pulse
      for (int i = 0; i < 3; i++) add(1, 8'(i), i == 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         add(1, 8'(8'h50 + i), i == 0, i == 7, 0, 1, 8, 1, 1, i % 4 == 3,
             word(32'h50 + i - 3), i == 3, 0, i == 1);
      add(0, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 1, 0);

      foreach (vecs[i]) begin
         tvalid = vecs[i].v; tdata = vecs[i].d; tuser = vecs[i].u; tlast = vecs[i].l;
         fifo_full = vecs[i].full; soft_resetn = vecs[i].sr;
         img_width = vecs[i].w; img_height = vecs[i].h;
         @(negedge clk);
         chk($sformatf("vec%0d_tready", i), tready, vecs[i].rdy);
         chk($sformatf("vec%0d_wr", i), wr_en, vecs[i].wr);
         if (vecs[i].wr) chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
         chk($sformatf("vec%0d_sof", i), sof, vecs[i].sof);
         chk($sformatf("vec%0d_done", i), done, vecs[i].done);
         chk($sformatf("vec%0d_err", i), err, vecs[i].err);
         @(posedge clk); #1;
      end
      tvalid = 0; tuser = 0; tlast = 0; fifo_full = 0; soft_resetn = 1;

      // 10-bit pixels: two pixels per 32-bit word
      tvalid_b = 1; tuser_b = 1; tdata_b = 10'h3FF;
      @(negedge clk); chk("p2_wr0", wr_b, 0);
      @(posedge clk); #1; tuser_b = 0; tdata_b = 10'h001;
      @(negedge clk); chk("p2_wr1", wr_b, 1); chk("p2_dout1", dout_b, 32'h000103FF);
      chk("p2_sof1", sof_b, 1);
      @(posedge clk); #1; tdata_b = 10'h002;
      @(negedge clk); chk("p2_wr2", wr_b, 0);
      @(posedge clk); #1; tdata_b = 10'h003; tlast_b = 1;
      @(negedge clk); chk("p2_wr3", wr_b, 1); chk("p2_dout3", dout_b, 32'h00030002);
      chk("p2_sof3", sof_b, 0); chk("p2_done_early", done_b, 0);
      @(posedge clk); #1; tvalid_b = 0; tlast_b = 0;
      @(negedge clk); chk("p2_done", done_b, 1); chk("p2_err", err_b, 0);
      @(posedge clk); #1;

      // randomized frames, garbage, errors and truncations under random backpressure
      rnd_on = 1; rnd_full_on = 1;
      begin
         bit need_good = 0;
         for (int s = 0; s < 40; s++) begin
            int kind = $urandom_range(0, 3);
            int wd = 4 * $urandom_range(1, 3), ht = $urandom_range(1, 3);
            if (need_good) kind = 1;
            need_good = 0;
            if (kind == 0) begin
               int n = $urandom_range(1, 4);
               for (int i = 0; i < n; i++) px(8'($urandom), 0, $urandom_range(0, 1) == 1);
            end else if (kind == 1) send_frame(wd, ht, wd * ht, 0);
            else if (kind == 2) send_frame(wd, ht, $urandom_range(1, wd * ht), 1);
            else begin
               send_frame(wd, ht, $urandom_range(1, wd * ht - 1), 0);
               need_good = 1;
            end
         end
         if (need_good) send_frame(8, 2, 16, 0);
      end
      rnd_full_on = 0;
      @(posedge clk); #2 fifo_full = 0;
      repeat (6) @(posedge clk);
      @(negedge clk); #1;
      rnd_on = 0;
      chk("rnd_missing_words", exp_q.size(), 0);
      chk("rnd_done_count", got_done, exp_done);
      chk("rnd_err_count", got_err, exp_err);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
